// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - MSB-first word serialiser with running ones count and mod-3 residue
module serial_word_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             done,
    output logic [3:0]       ones_cnt,
    output logic             mod3_zero
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [3:0]       bit_idx;
    logic [1:0]       residue;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            ones_cnt <= '0;
            residue  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg    <= in_data;
                        bit_idx  <= '0;
                        ones_cnt <= '0;
                        residue  <= '0;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Counts reflect completed bits, so they update as the bit leaves dout.
                    if (shreg[WIDTH-1]) begin
                        ones_cnt <= ones_cnt + 4'd1;
                        residue  <= (residue == 2'd2) ? 2'd0 : residue + 2'd1;
                    end
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == LAST_IDX)
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // dout is gated by state so the detector never sees a stray one outside SHIFT.
    assign in_ready   = (state == S_IDLE);
    assign dout_valid = (state == S_SHIFT);
    assign dout       = (state == S_SHIFT) && shreg[WIDTH-1];
    assign done       = (state == S_DONE);
    assign mod3_zero  = (residue == 2'd0);
endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - scoreboard bench for serial_word_tx
module tb_serial_word_tx;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready, dout, dout_valid, done, mod3_zero;
    logic [3:0]       ones_cnt;

    serial_word_tx #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid), .done(done),
        .ones_cnt(ones_cnt), .mod3_zero(mod3_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       b;
        logic [3:0] ones;
        logic       m3;
    } exp_t;

    exp_t exp_q[$];
    exp_t done_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   accept_cnt = 0;
    int   accept_cyc[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference detector: ones count and mod-3 residue built from the accepted word.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            automatic logic [3:0] n = 0;
            automatic int r = 0;
            automatic logic [WIDTH-1:0] w = in_data;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                exp_q.push_back('{b: w[i], ones: n, m3: (r == 0)});
                if (w[i]) begin
                    n = n + 4'd1;
                    r = (r + 1) % 3;
                end
            end
            done_q.push_back('{b: 1'b0, ones: n, m3: (r == 0)});
            accept_cyc.push_back(cyc);
            accept_cnt <= accept_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) begin
                if (exp_q.size() == 0) chk("unexpected_bit", 8'd1, 8'd0);
                else begin
                    automatic exp_t e = exp_q.pop_front();
                    chk("dout", {7'd0, dout}, {7'd0, e.b});
                    chk("ones_cnt", {4'd0, ones_cnt}, {4'd0, e.ones});
                    chk("mod3_zero", {7'd0, mod3_zero}, {7'd0, e.m3});
                end
            end else if (dout !== 1'b0) begin
                chk("dout_idle_zero", {7'd0, dout}, 8'd0);
            end
            if (done) begin
                if (done_q.size() == 0) chk("spurious_done", 8'd1, 8'd0);
                else begin
                    automatic exp_t d = done_q.pop_front();
                    chk("final_ones", {4'd0, ones_cnt}, {4'd0, d.ones});
                    chk("final_mod3", {7'd0, mod3_zero}, {7'd0, d.m3});
                    chk("done_dv", {7'd0, dout_valid}, 8'd0);
                    chk("done_remaining_bits", 8'(exp_q.size()), 8'd0);
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] w);
        automatic bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 8'd1, 8'd0);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        automatic bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done_q.size() == 0 && in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 8'd1, 8'd0);
    endtask

    task automatic wait_accept(input int target);
        automatic bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (accept_cnt >= target) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 8'(accept_cnt), 8'(target));
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_dout", {7'd0, dout}, 8'd0);
        chk("rst_dout_valid", {7'd0, dout_valid}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_ones_cnt", {4'd0, ones_cnt}, 8'd0);
        chk("rst_mod3_zero", {7'd0, mod3_zero}, 8'd1);
    endtask

    initial begin
        int base, t0, t1;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Directed words, including all-ones and all-zeros boundaries
        send(8'b1011_0110); wait_idle();
        chk("t1_final_ones", {4'd0, ones_cnt}, 8'd5);
        chk("t1_final_mod3", {7'd0, mod3_zero}, 8'd0);
        send(8'b1110_0000); wait_idle();
        chk("t2_final_ones", {4'd0, ones_cnt}, 8'd3);
        chk("t2_final_mod3", {7'd0, mod3_zero}, 8'd1);
        send(8'hFF); wait_idle();
        chk("t3_ff_ones", {4'd0, ones_cnt}, 8'd8);
        chk("t3_ff_mod3", {7'd0, mod3_zero}, 8'd0);
        send(8'h00); wait_idle();
        chk("t3_00_ones", {4'd0, ones_cnt}, 8'd0);
        chk("t3_00_mod3", {7'd0, mod3_zero}, 8'd1);

        // in_valid held high; in_data changes mid-word
        base = accept_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        wait_accept(base + 1);
        in_data = 8'hC3;
        wait_accept(base + 2);
        in_valid = 1'b0;
        t0 = accept_cyc[base];
        t1 = accept_cyc[base + 1];
        chk("t4_accept_spacing", 8'(t1 - t0), 8'(WIDTH + 2));
        wait_idle();

        // Abort during bit 3
        send(8'hA5);
        repeat (3) @(negedge clk);
        chk("t5_pre_abort_dv", {7'd0, dout_valid}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'h3C); wait_idle();
        chk("t5_final_ones", {4'd0, ones_cnt}, 8'd4);
        chk("t5_final_mod3", {7'd0, mod3_zero}, 8'd0);

        // Random back-to-back run against the reference detector
        base = accept_cnt;
        @(negedge clk);
        in_data  = 8'($urandom);
        in_valid = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            wait_accept(base + i);
            in_data = 8'($urandom);
        end
        in_valid = 1'b0;
        wait_idle();

        chk("leftover_bits", 8'(exp_q.size()), 8'd0);
        chk("leftover_done", 8'(done_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
